// File: rtl/parking_pkg.sv
// parking_pkg: event encoding, queue depth and occupancy states shared by the parking event sequencer.
package parking_pkg;
  localparam logic EVT_ENTRY = 1'b0;
  localparam logic EVT_EXIT = 1'b1;
  localparam int FIFO_DEPTH = 2;
  typedef struct packed {
    logic typ;
    logic [1:0] slot;
  } evt_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer, clean level and level-change strobe for one raw bit.
// SENSOR_DEBOUNCE_EN: level follows only after DEB_SAMPLES equal samples; otherwise it tracks the synchronizer.
module sensor_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en_i,
  input  logic raw_i,
  output logic level_o,
  output logic qual_o
);
  localparam int CW = $clog2(DEB_SAMPLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, diff, done;
  always_comb begin
    diff = sync_q[1] ^ lvl_q;
    done = sample_en_i & diff & (cnt_q == CW'(DEB_SAMPLES - 1));
    cnt_d = !sample_en_i ? cnt_q : (!diff || done) ? '0 : cnt_q + 1'b1;
`ifdef SENSOR_DEBOUNCE_EN
    lvl_d = done ? sync_q[1] : lvl_q;
`else
    lvl_d = sync_q[1];
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  assign level_o = lvl_q;
  assign qual_o = lvl_d ^ lvl_q;
endmodule

// File: rtl/parking_event_sequencer.sv
// parking_event_sequencer: clean entry/exit rising edges become {type, slot} events in a 2-entry queue.
// SENSOR_DEBOUNCE_EN selects sample-count debounce in every sensor_debounce instance.
module parking_event_sequencer
  import parking_pkg::*;
#(
  parameter int DEB_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] switch,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic       evt_type,
  output logic [1:0] evt_slot,
  output logic       overflow
);
  logic [3:0] raw, lvl, qual;
  logic [1:0] sw_clean, keep;
  logic [2:0] total;
  logic pop, rise_en, rise_ex, ovf_q, ovf_d, valid_q;
  evt_t head_q, head_d, tail_q, tail_d, ent, ext;
  occ_e occ_q, occ_d;
  assign raw = {switch, exit_sensor, entry_sensor};
  for (genvar i = 0; i < 4; i++) begin : g_deb
    sensor_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk(clk),
      .reset(reset),
      .sample_en_i(sample_en),
      .raw_i(raw[i]),
      .level_o(lvl[i]),
      .qual_o(qual[i])
    );
  end
  // Slot is the switch level after this cycle's qualification; entry always ranks ahead of exit.
  always_comb begin
    rise_en = qual[0] & ~lvl[0];
    rise_ex = qual[1] & ~lvl[1];
    sw_clean = lvl[3:2] ^ qual[3:2];
    ent = '{typ: EVT_ENTRY, slot: sw_clean};
    ext = '{typ: EVT_EXIT, slot: sw_clean};
    pop = valid_q & evt_ready;
    keep = occ_q - {1'b0, pop};
    total = {1'b0, keep} + {2'b0, rise_en} + {2'b0, rise_ex};
    head_d = keep != 2'd0 ? (pop ? tail_q : head_q) : rise_en ? ent : rise_ex ? ext : head_q;
    tail_d = keep == 2'd2 ? tail_q : keep == 2'd1 ? (rise_en ? ent : ext) : ext;
    occ_d = total > 3'(FIFO_DEPTH) ? FULL : occ_e'(total[1:0]);
    ovf_d = ovf_q | (total > 3'(FIFO_DEPTH));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      occ_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q <= ovf_d;
      valid_q <= occ_d != EMPTY;
    end
  assign evt_valid = valid_q;
  assign evt_type = head_q.typ;
  assign evt_slot = head_q.slot;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_parking_event_sequencer.sv
// tb_parking_event_sequencer: directed and random scenarios checked against a queue-based reference model.
module tb_parking_event_sequencer;
  localparam int DEB = 4;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int GLITCH_EVTS = 0;
`else
  localparam int GLITCH_EVTS = 1;
`endif
  logic clk = 0, reset, sample_en, entry_sensor, exit_sensor, evt_ready;
  logic [1:0] switch;
  logic evt_valid, evt_type, overflow;
  logic [1:0] evt_slot;
  int errors = 0, checks = 0, sc = 0;

  parking_event_sequencer #(.DEB_SAMPLES(DEB)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .entry_sensor(entry_sensor),
    .exit_sensor(exit_sensor), .switch(switch), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_slot(evt_slot), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    sample_en = 0;
    forever begin
      @(negedge clk);
      sc++;
      sample_en = (sc % 4 == 0);
    end
  end

  // Reference model: channels 0 entry, 1 exit, 2..3 switch bits; events kept in a bounded queue.
  logic [1:0] m_sy[4];
  logic m_lvl[4];
  int m_run[4];
  logic [3:0] m_raw, m_rose;
  logic [2:0] mq[$];
  logic m_ovf;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      for (int c = 0; c < 4; c++) begin
        m_sy[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
      end
    end else begin
      m_raw = {switch, exit_sensor, entry_sensor};
      for (int c = 0; c < 4; c++) begin
        m_rose[c] = 0;
`ifdef SENSOR_DEBOUNCE_EN
        if (sample_en) begin
          if (m_sy[c][1] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
              m_lvl[c] = m_sy[c][1]; m_run[c] = 0; m_rose[c] = m_lvl[c];
            end
          end else m_run[c] = 0;
        end
`else
        if (m_sy[c][1] != m_lvl[c]) begin
          m_lvl[c] = m_sy[c][1]; m_rose[c] = m_lvl[c];
        end
`endif
        m_sy[c] = {m_sy[c][0], m_raw[c]};
      end
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (m_rose[0]) begin
        if (mq.size() < 2) mq.push_back({1'b0, m_lvl[3], m_lvl[2]}); else m_ovf = 1;
      end
      if (m_rose[1]) begin
        if (mq.size() < 2) mq.push_back({1'b1, m_lvl[3], m_lvl[2]}); else m_ovf = 1;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({evt_valid, evt_type, evt_slot, overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_state got=%b exp=00000", {evt_valid, evt_type, evt_slot, overflow});
    end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({evt_valid, overflow} !== 2'b0) begin
      errors++; $display("FAIL reset_release got=%b exp=00", {evt_valid, overflow});
    end
  endtask

  task automatic test_single_entry();
    int nv = 0, lat = -1;
    evt_ready = 1; switch = 2;
    repeat (30) @(negedge clk);
    entry_sensor = 1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (mq.size() > 0) || overflow !== m_ovf || (evt_valid === 1'b1 && {evt_type, evt_slot} !== mq[0])) begin
        errors++; $display("FAIL single_model t=%0t valid=%b head=%b ovf=%b exp_valid=%b exp_ovf=%b", $time, evt_valid, {evt_type, evt_slot}, overflow, mq.size() > 0, m_ovf);
      end
      if (evt_valid === 1'b1) begin
        nv++;
        if (lat < 0) lat = k;
        checks++;
        if ({evt_type, evt_slot} !== 3'b010) begin
          errors++; $display("FAIL single_payload got=%b exp=010", {evt_type, evt_slot});
        end
      end
      if (k == 24) entry_sensor = 0;
    end
    checks++;
    if (nv !== 1) begin
      errors++; $display("FAIL single_count got=%0d exp=1", nv);
    end
`ifndef SENSOR_DEBOUNCE_EN
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL nodeb_latency got=%0d exp=3", lat);
    end
`endif
  endtask

  task automatic test_glitch();
    int nv = 0;
    evt_ready = 1;
    repeat (30) @(negedge clk);
    entry_sensor = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (mq.size() > 0) || overflow !== m_ovf || (evt_valid === 1'b1 && {evt_type, evt_slot} !== mq[0])) begin
        errors++; $display("FAIL glitch_model t=%0t valid=%b head=%b ovf=%b exp_valid=%b exp_ovf=%b", $time, evt_valid, {evt_type, evt_slot}, overflow, mq.size() > 0, m_ovf);
      end
      if (evt_valid === 1'b1) nv++;
      if (k == 8) entry_sensor = 0;
    end
    checks++;
    if (nv !== GLITCH_EVTS || overflow !== 1'b0) begin
      errors++; $display("FAIL glitch_events got=%0d ovf=%b exp=%0d ovf=0", nv, overflow, GLITCH_EVTS);
    end
  endtask

  task automatic test_simultaneous();
    evt_ready = 0; switch = 1;
    repeat (30) @(negedge clk);
    entry_sensor = 1; exit_sensor = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (mq.size() > 0) || overflow !== m_ovf || (evt_valid === 1'b1 && {evt_type, evt_slot} !== mq[0])) begin
        errors++; $display("FAIL simul_model t=%0t valid=%b head=%b ovf=%b exp_valid=%b exp_ovf=%b", $time, evt_valid, {evt_type, evt_slot}, overflow, mq.size() > 0, m_ovf);
      end
    end
    checks++;
    if ({evt_valid, evt_type, evt_slot, overflow} !== 5'b10010) begin
      errors++; $display("FAIL simul_head_entry got=%b exp=10010", {evt_valid, evt_type, evt_slot, overflow});
    end
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    checks++;
    if ({evt_valid, evt_type, evt_slot} !== 4'b1101) begin
      errors++; $display("FAIL simul_head_exit got=%b exp=1101", {evt_valid, evt_type, evt_slot});
    end
    entry_sensor = 0; exit_sensor = 0;
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL simul_drain got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    evt_ready = 0; switch = 1;
    repeat (30) @(negedge clk);
    entry_sensor = 1; exit_sensor = 1;
    repeat (30) @(negedge clk);
    entry_sensor = 0; exit_sensor = 0;
    repeat (30) @(negedge clk);
    entry_sensor = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (mq.size() > 0) || overflow !== m_ovf || (evt_valid === 1'b1 && {evt_type, evt_slot} !== mq[0])) begin
        errors++; $display("FAIL ovf_model t=%0t valid=%b head=%b ovf=%b exp_valid=%b exp_ovf=%b", $time, evt_valid, {evt_type, evt_slot}, overflow, mq.size() > 0, m_ovf);
      end
    end
    checks++;
    if ({evt_valid, evt_type, evt_slot, overflow} !== 5'b10011) begin
      errors++; $display("FAIL ovf_set got=%b exp=10011", {evt_valid, evt_type, evt_slot, overflow});
    end
    evt_ready = 1;
    repeat (4) @(negedge clk);
    checks++;
    if ({evt_valid, overflow} !== 2'b01) begin
      errors++; $display("FAIL ovf_sticky got=%b exp=01", {evt_valid, overflow});
    end
    entry_sensor = 0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_midway();
    int nv = 0;
    evt_ready = 0; switch = 3;
    repeat (30) @(negedge clk);
    entry_sensor = 1; exit_sensor = 1;
    repeat (30) @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_prefill got=%b exp=1", evt_valid);
    end
    exit_sensor = 0;
    reset = 1;
    #1;
    checks++;
    if ({evt_valid, evt_type, evt_slot, overflow} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_async got=%b exp=00000", {evt_valid, evt_type, evt_slot, overflow});
    end
    @(negedge clk);
    reset = 0; evt_ready = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (mq.size() > 0) || overflow !== m_ovf || (evt_valid === 1'b1 && {evt_type, evt_slot} !== mq[0])) begin
        errors++; $display("FAIL rst_mid_model t=%0t valid=%b head=%b ovf=%b exp_valid=%b exp_ovf=%b", $time, evt_valid, {evt_type, evt_slot}, overflow, mq.size() > 0, m_ovf);
      end
      if (evt_valid === 1'b1) nv++;
    end
    checks++;
    if (nv !== 1) begin
      errors++; $display("FAIL rst_mid_count got=%0d exp=1", nv);
    end
    entry_sensor = 0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (mq.size() > 0) || overflow !== m_ovf || (evt_valid === 1'b1 && {evt_type, evt_slot} !== mq[0])) begin
        errors++; $display("FAIL random_model t=%0t valid=%b head=%b ovf=%b exp_valid=%b exp_ovf=%b", $time, evt_valid, {evt_type, evt_slot}, overflow, mq.size() > 0, m_ovf);
      end
      if ($urandom_range(0, 29) == 0) entry_sensor = ~entry_sensor;
      if ($urandom_range(0, 29) == 0) exit_sensor = ~exit_sensor;
      if ($urandom_range(0, 59) == 0) switch = 2'($urandom_range(0, 3));
      evt_ready = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
    end
  endtask

  initial begin
    reset = 1; entry_sensor = 0; exit_sensor = 0; switch = 0; evt_ready = 0;
    test_reset();
    test_single_entry();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_reset_midway();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
